// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: datapath status in, pipeline register
// enables/flushes and PC control out.
interface pipeline_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 32
);
    logic                   ihit;
    logic                   dhit;
    logic                   dREN_EX_MEM;
    logic                   dWEN_EX_MEM;
    logic                   dREN_ID_EX;
    logic [4:0]             Rt_ID_EX;
    logic [4:0]             Rs_IF_ID;
    logic [4:0]             Rt_IF_ID;
    logic                   jump_IF_ID;
    logic                   branch_EX_MEM;
    logic                   zero_EX_MEM;
    logic                   halt_EX_MEM;

    logic                   enable_IF_ID;
    logic                   enable_ID_EX;
    logic                   enable_EX_MEM;
    logic                   enable_MEM_WB;
    logic                   flush_IF_ID;
    logic                   flush_ID_EX;
    logic                   flush_EX_MEM;
    logic                   flush_MEM_WB;
    logic                   pc_en;
    logic [1:0]             pc_src;
    logic                   halt;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Datapath side
    modport master (
        output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, jump_IF_ID,
               branch_EX_MEM, zero_EX_MEM, halt_EX_MEM,
        input  enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_en, pc_src, halt, mem_timeout, stall_cnt
    );

    // Controller side
    modport slave (
        input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, jump_IF_ID,
               branch_EX_MEM, zero_EX_MEM, halt_EX_MEM,
        output enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_en, pc_src, halt, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline:
// reset bubble, memory-wait stalls, load-use interlock, jump/branch
// squash, halt drain and a sticky data-wait watchdog.
module pipeline_ctrl #(
    parameter int unsigned DWAIT_MAX   = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input logic            CLK,
    input logic            nRST,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned   CW     = $clog2(DWAIT_MAX + 1);
    localparam logic [CW-1:0] LP_MAX = CW'(DWAIT_MAX);

    typedef enum logic [2:0] {
        S_BUBBLE,
        S_RUN,
        S_DWAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_wait;
    logic                   r_halt;
    logic                   r_mem_timeout;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_dstall;
    logic                   w_branch;
    logic                   w_loaduse;
    logic                   w_active;
    logic [3:0]             w_en;   // {IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic [3:0]             w_fl;   // {IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic                   w_pc_en;
    logic [1:0]             w_pc_src;

    // Hazard detection; in DWAIT only dhit matters, and its arrival
    // suppresses the data stall so the remaining rules apply that cycle.
    always_comb begin
        w_dstall  = (r_state == S_DWAIT) ? !bus.dhit
                  : ((bus.dREN_EX_MEM | bus.dWEN_EX_MEM) & !bus.dhit);
        w_branch  = bus.branch_EX_MEM & bus.zero_EX_MEM;
        w_loaduse = bus.dREN_ID_EX && (bus.Rt_ID_EX != 5'd0) &&
                    ((bus.Rt_ID_EX == bus.Rs_IF_ID) || (bus.Rt_ID_EX == bus.Rt_IF_ID));
        w_active  = (r_state == S_RUN) || (r_state == S_DWAIT);
    end

    // Output and next-state decode from state plus current hazards
    always_comb begin
        w_en     = '1;
        w_fl     = '0;
        w_pc_en  = 1'b1;
        w_pc_src = 2'd0;
        w_next   = r_state;
        unique case (r_state)
            S_BUBBLE: begin
                w_en    = '0;
                w_fl    = '1;
                w_pc_en = 1'b0;
                w_next  = S_RUN;
            end
            S_RUN, S_DWAIT: begin
                w_next = S_RUN;
                if (w_dstall) begin
                    w_en    = 4'b0001;
                    w_fl    = 4'b0001;
                    w_pc_en = 1'b0;
                    w_next  = S_DWAIT;
                end else if (bus.halt_EX_MEM) begin
                    w_fl    = 4'b1110;
                    w_pc_en = 1'b0;
                    w_next  = S_DRAIN;
                end else if (w_branch) begin
                    w_fl     = 4'b1110;
                    w_pc_src = 2'd2;
                end else if (bus.jump_IF_ID) begin
                    // A jump without a completed fetch degrades to a fetch stall
                    w_fl = 4'b1000;
                    if (bus.ihit) begin
                        w_pc_src = 2'd1;
                    end else begin
                        w_pc_en = 1'b0;
                    end
                end else if (w_loaduse) begin
                    w_en    = 4'b0111;
                    w_fl    = 4'b0100;
                    w_pc_en = 1'b0;
                end else if (!bus.ihit) begin
                    w_fl    = 4'b1000;
                    w_pc_en = 1'b0;
                end
            end
            S_DRAIN: begin
                w_fl    = 4'b1110;
                w_pc_en = 1'b0;
                w_next  = S_HALTED;
            end
            S_HALTED: begin
                w_en    = '0;
                w_pc_en = 1'b0;
            end
            default: begin
                w_next = S_BUBBLE;
            end
        endcase
    end

    // State, watchdog, sticky flags and stall counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= S_BUBBLE;
            r_wait        <= '0;
            r_halt        <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_DWAIT) && !bus.dhit) begin
                if (r_wait != LP_MAX) begin
                    r_wait <= r_wait + CW'(1);
                end
                if (r_wait >= LP_MAX - CW'(1)) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait <= '0;
            end

            if (r_state == S_DRAIN) begin
                r_halt <= 1'b1;
            end

            if (w_active && !w_pc_en) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    // Drive the bus
    always_comb begin
        bus.enable_IF_ID  = w_en[3];
        bus.enable_ID_EX  = w_en[2];
        bus.enable_EX_MEM = w_en[1];
        bus.enable_MEM_WB = w_en[0];
        bus.flush_IF_ID   = w_fl[3];
        bus.flush_ID_EX   = w_fl[2];
        bus.flush_EX_MEM  = w_fl[1];
        bus.flush_MEM_WB  = w_fl[0];
        bus.pc_en         = w_pc_en;
        bus.pc_src        = w_pc_src;
        bus.halt          = r_halt;
        bus.mem_timeout   = r_mem_timeout;
        bus.stall_cnt     = r_stall_cnt;
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a
// randomized run, all checked against a rule-level reference model.
module tb_pipeline_ctrl;
    localparam int unsigned DMAX = 64;

    // Output vector layout: {en IF,ID,EX,MW, fl IF,ID,EX,MW, pc_en, pc_src[1:0]}
    localparam logic [10:0] BUBV = 11'b0000_1111_0_00;
    localparam logic [10:0] RUNV = 11'b1111_0000_1_00;
    localparam logic [10:0] STLV = 11'b0001_0001_0_00;
    localparam logic [10:0] LUV  = 11'b0111_0100_0_00;
    localparam logic [10:0] BRV  = 11'b1111_1110_1_10;
    localparam logic [10:0] JMPV = 11'b1111_1000_1_01;
    localparam logic [10:0] NOFV = 11'b1111_1000_0_00;
    localparam logic [10:0] HLTV = 11'b1111_1110_0_00;
    localparam logic [10:0] OFFV = 11'b0000_0000_0_00;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.STALL_CNT_W(32)) bus();

    pipeline_ctrl #(
        .DWAIT_MAX  (DMAX),
        .STALL_CNT_W(32)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 bubble, 1 run, 2 data wait, 3 drain, 4 halted
    int          m_phase = 0;
    int          m_wait  = 0;
    logic        m_halt  = 1'b0;
    logic        m_to    = 1'b0;
    logic [31:0] m_stall = '0;

    // Which hazard rule governs a running cycle (0 = none)
    function automatic int rule_of();
        if (m_phase == 2 ? !bus.dhit : ((bus.dREN_EX_MEM || bus.dWEN_EX_MEM) && !bus.dhit)) return 1;
        if (bus.halt_EX_MEM) return 2;
        if (bus.branch_EX_MEM && bus.zero_EX_MEM) return 3;
        if (bus.jump_IF_ID) return bus.ihit ? 4 : 6;
        if (bus.dREN_ID_EX && bus.Rt_ID_EX != 0 &&
            (bus.Rt_ID_EX == bus.Rs_IF_ID || bus.Rt_ID_EX == bus.Rt_IF_ID)) return 5;
        if (!bus.ihit) return 6;
        return 0;
    endfunction

    function automatic logic [10:0] exp_vec();
        case (m_phase)
            0: return BUBV;
            3: return HLTV;
            4: return OFFV;
            default: begin
                case (rule_of())
                    1: return STLV;
                    2: return HLTV;
                    3: return BRV;
                    4: return JMPV;
                    5: return LUV;
                    6: return NOFV;
                    default: return RUNV;
                endcase
            end
        endcase
    endfunction

    function automatic bit exp_pc_stalled();
        int r;
        r = rule_of();
        return (r == 1) || (r == 2) || (r == 5) || (r == 6);
    endfunction

    function automatic logic [10:0] got_vec();
        return {bus.enable_IF_ID, bus.enable_ID_EX, bus.enable_EX_MEM, bus.enable_MEM_WB,
                bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM, bus.flush_MEM_WB,
                bus.pc_en, bus.pc_src};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_halt  <= 1'b0;
            m_to    <= 1'b0;
            m_stall <= '0;
        end else begin
            case (m_phase)
                0: m_phase <= 1;
                1, 2: begin
                    if (rule_of() == 1)      m_phase <= 2;
                    else if (rule_of() == 2) m_phase <= 3;
                    else                     m_phase <= 1;
                    if (exp_pc_stalled()) m_stall <= m_stall + 1;
                    if (m_phase == 2 && !bus.dhit) begin
                        if (m_wait < DMAX) m_wait <= m_wait + 1;
                        if (m_wait + 1 >= DMAX) m_to <= 1'b1;
                    end else begin
                        m_wait <= 0;
                    end
                end
                3: begin
                    m_phase <= 4;
                    m_halt  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic set_idle();
        bus.ihit          = 1'b1;
        bus.dhit          = 1'b1;
        bus.dREN_EX_MEM   = 1'b0;
        bus.dWEN_EX_MEM   = 1'b0;
        bus.dREN_ID_EX    = 1'b0;
        bus.Rt_ID_EX      = 5'd0;
        bus.Rs_IF_ID      = 5'd0;
        bus.Rt_IF_ID      = 5'd0;
        bus.jump_IF_ID    = 1'b0;
        bus.branch_EX_MEM = 1'b0;
        bus.zero_EX_MEM   = 1'b0;
        bus.halt_EX_MEM   = 1'b0;
    endtask

    // Reset pulse inside a low clock phase; leaves the DUT in BUBBLE
    task automatic pulse_reset();
        @(negedge CLK);
        set_idle();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        #1 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        total++;
        if ({got_vec(), bus.halt, bus.mem_timeout, bus.stall_cnt} !== {BUBV, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_hold: got %b/%b/%b/%0d exp %b/0/0/0", got_vec(), bus.halt, bus.mem_timeout, bus.stall_cnt, BUBV);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++;
        if (got_vec() !== BUBV || exp_vec() !== BUBV) begin
            bad++;
            $display("FAIL reset_cycle0: got %b model %b exp %b", got_vec(), exp_vec(), BUBV);
        end
        @(negedge CLK);
        #1;
        total++;
        if (got_vec() !== RUNV || exp_vec() !== RUNV) begin
            bad++;
            $display("FAIL reset_cycle1: got %b model %b exp %b", got_vec(), exp_vec(), RUNV);
        end
    endtask

    task automatic test_dwait_short();
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            set_idle();
            if (k <= 4) bus.dREN_EX_MEM = 1'b1;
            if (k <= 3) bus.dhit = 1'b0;
            #1;
            total++;
            if (got_vec() !== ((k <= 3) ? STLV : RUNV) || got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL dwait_short[%0d]: got %b model %b", k, got_vec(), exp_vec());
            end
        end
        total++;
        if (bus.stall_cnt !== 32'd3 || m_stall !== 32'd3) begin
            bad++;
            $display("FAIL dwait_stall_cnt: got %0d model %0d exp 3", bus.stall_cnt, m_stall);
        end
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            set_idle();
            bus.dREN_ID_EX = (k != 1);
            bus.Rt_ID_EX   = (k == 2) ? 5'd0 : 5'd5;
            bus.Rs_IF_ID   = (k == 3) ? 5'd7 : ((k == 2) ? 5'd0 : 5'd5);
            bus.Rt_IF_ID   = (k == 3) ? 5'd5 : 5'd9;
            #1;
            total++;
            if (got_vec() !== ((k == 0 || k == 3) ? LUV : RUNV) || got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL load_use[%0d]: got %b model %b", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_branch_jump();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            set_idle();
            bus.jump_IF_ID    = 1'b1;
            bus.branch_EX_MEM = (k == 0);
            bus.zero_EX_MEM   = (k == 0);
            bus.ihit          = (k == 1);
            #1;
            total++;
            if (got_vec() !== ((k == 0) ? BRV : ((k == 1) ? JMPV : NOFV)) || got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL branch_jump[%0d]: got %b model %b", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_halt();
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            set_idle();
            if (k == 0) bus.halt_EX_MEM = 1'b1;
            if (k >= 3) begin
                bus.ihit          = 1'($urandom);
                bus.dREN_EX_MEM   = 1'($urandom);
                bus.dhit          = 1'b0;
                bus.branch_EX_MEM = 1'b1;
                bus.zero_EX_MEM   = 1'b1;
            end
            #1;
            total++;
            if (got_vec() !== ((k < 2) ? HLTV : OFFV) || bus.halt !== (k >= 2) ||
                got_vec() !== exp_vec() || bus.halt !== m_halt) begin
                bad++;
                $display("FAIL halt[%0d]: got %b halt=%b model %b halt=%b", k, got_vec(), bus.halt, exp_vec(), m_halt);
            end
        end
        nRST = 1'b0;
        #1;
        total++;
        if (got_vec() !== BUBV || bus.halt !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: got %b halt=%b exp %b halt=0", got_vec(), bus.halt, BUBV);
        end
        nRST = 1'b1;
        set_idle();
        @(negedge CLK);
        #1;
        total++;
        if (got_vec() !== RUNV || bus.halt !== 1'b0) begin
            bad++;
            $display("FAIL halt_rerun: got %b halt=%b exp %b halt=0", got_vec(), bus.halt, RUNV);
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        for (int k = 1; k <= 70; k++) begin
            @(negedge CLK);
            set_idle();
            bus.dWEN_EX_MEM = 1'b1;
            bus.dhit        = 1'b0;
            #1;
            total++;
            // 1 RUN stall cycle, then DWAIT; flag lands after the 64th DWAIT cycle
            if (got_vec() !== STLV || bus.mem_timeout !== (k >= 66) || bus.mem_timeout !== m_to) begin
                bad++;
                $display("FAIL timeout[%0d]: got %b to=%b model_to=%b", k, got_vec(), bus.mem_timeout, m_to);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            set_idle();
            if (k == 0) bus.dWEN_EX_MEM = 1'b1;
            #1;
            total++;
            if (got_vec() !== RUNV || bus.mem_timeout !== 1'b1 || bus.stall_cnt !== 32'd70) begin
                bad++;
                $display("FAIL timeout_sticky[%0d]: got %b to=%b stall=%0d exp %b to=1 stall=70", k, got_vec(), bus.mem_timeout, bus.stall_cnt, RUNV);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) pulse_reset();
            else @(negedge CLK);
            bus.ihit          = ($urandom_range(0, 99) < 80);
            bus.dhit          = ($urandom_range(0, 99) < 60);
            bus.dREN_EX_MEM   = ($urandom_range(0, 99) < 20);
            bus.dWEN_EX_MEM   = ($urandom_range(0, 99) < 10);
            bus.dREN_ID_EX    = ($urandom_range(0, 99) < 30);
            bus.Rt_ID_EX      = 5'($urandom_range(0, 3));
            bus.Rs_IF_ID      = 5'($urandom_range(0, 3));
            bus.Rt_IF_ID      = 5'($urandom_range(0, 3));
            bus.jump_IF_ID    = ($urandom_range(0, 99) < 15);
            bus.branch_EX_MEM = ($urandom_range(0, 99) < 15);
            bus.zero_EX_MEM   = 1'($urandom);
            bus.halt_EX_MEM   = ($urandom_range(0, 99) < 2);
            #1;
            total++;
            if ({got_vec(), bus.halt, bus.mem_timeout, bus.stall_cnt} !== {exp_vec(), m_halt, m_to, m_stall}) begin
                bad++;
                $display("FAIL random[%0d]: got %b h=%b to=%b st=%0d exp %b h=%b to=%b st=%0d", i,
                         got_vec(), bus.halt, bus.mem_timeout, bus.stall_cnt, exp_vec(), m_halt, m_to, m_stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dwait_short();
        test_load_use();
        test_branch_jump();
        test_halt();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
